// File: rtl/oric_tape_pkg.sv
// Shared types and helpers for the Oric cassette playback stage: FSM state
// encoding, frame geometry and the per-byte frame builder.
package oric_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEADIN = 3'd1,
        ST_FETCH  = 3'd2,
        ST_BIT_HI = 3'd3,
        ST_BIT_LO = 3'd4
    } tape_state_t;

    localparam int FRAME_BITS = 14;
    localparam int STOP_BITS  = 4;

    // Odd parity: the data bits plus this bit always hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame is shifted out LSB first: start, 8 data, parity, stop bits.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {{STOP_BITS{1'b1}}, odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/oric_tape_player_if.sv
// HPS ioctl download port as seen by the tape player: a byte-write bus that
// the host drives (master) and the player samples (slave).
interface oric_tape_player_if #(
    parameter int ADDR_W = 16
);
    // wr is a one-cycle strobe; addr/dout are valid in that cycle. There is no
    // back-pressure: the slave must accept every strobe.
    logic              download;
    logic [7:0]        index;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;

    modport master (output download, output index, output wr, output addr, output dout);
    modport slave  (input  download, input  index, input  wr, input  addr, input  dout);
endinterface

// File: rtl/oric_tape_buf.sv
// Single-port synchronous byte RAM holding the captured tape image; writes
// take the port when enabled, otherwise the addressed byte is read out registered.
module oric_tape_buf #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/oric_tape_player.sv
// Oric cassette playback: captures a tape image from the ioctl port and replays
// it as a pulse train for K7_TAPEIN. Optional ORIC_TAPE_AUTOPLAY_EN starts playback
// when a tape download ends.
module oric_tape_player
    import oric_tape_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter logic [7:0] TAPE_INDEX = 8'd1,
    parameter int         HALF_CYC   = 4992,
    parameter int         LEAD_CYC   = 2400000
) (
    input  logic                clk_sys,
    input  logic                reset,
    oric_tape_player_if.slave   ioctl,
    input  logic                play,
    input  logic                stop,
    output logic                tape_out,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     length,
    output tape_state_t         state_dbg
);

    logic                  dl_tape, dl_q, dl_start, wr_en;
    logic                  play_q, play_rise, start_req;
    logic [ADDR_W:0]       wr_len, ptr_inc;
    logic [ADDR_W-1:0]     ram_addr;
    logic [7:0]            rdata;

    tape_state_t           state, state_n;
    logic [31:0]           cnt, cnt_n, low_len;
    logic [ADDR_W-1:0]     ptr, ptr_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic [3:0]            bit_idx, bit_idx_n;
    logic                  done_n, loading, loading_n;

    assign dl_tape   = ioctl.download && (ioctl.index == TAPE_INDEX);
    assign dl_start  = dl_tape && !dl_q;
    assign wr_en     = dl_tape && ioctl.wr;
    assign wr_len    = {1'b0, ioctl.addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign ptr_inc   = {1'b0, ptr} + {{ADDR_W{1'b0}}, 1'b1};
    assign play_rise = play && !play_q;
    assign ram_addr  = wr_en ? ioctl.addr : ptr;
    assign low_len   = shreg[0] ? 32'(HALF_CYC) : 32'(2 * HALF_CYC);

`ifdef ORIC_TAPE_AUTOPLAY_EN
    assign start_req = play_rise || (dl_q && !dl_tape && (length != '0));
`else
    assign start_req = play_rise;
`endif

    oric_tape_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk_sys (clk_sys),
        .we      (wr_en),
        .addr    (ram_addr),
        .wdata   (ioctl.dout),
        .rdata   (rdata)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q   <= 1'b0;
            play_q <= 1'b0;
            length <= '0;
        end else begin
            dl_q   <= dl_tape;
            play_q <= play;
            if (wr_en) begin
                if (dl_start || (wr_len > length)) length <= wr_len;
            end else if (dl_start) begin
                length <= '0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
            loading <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ptr     <= ptr_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            done    <= done_n;
            loading <= loading_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        done_n    = done;
        loading_n = loading;
        // A new tape download outranks stop, which outranks everything else.
        if (dl_start) begin
            state_n   = ST_IDLE;
            cnt_n     = '0;
            loading_n = 1'b0;
            done_n    = 1'b0;
        end else if (stop) begin
            state_n   = ST_IDLE;
            cnt_n     = '0;
            loading_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (length != '0) begin
                            state_n = ST_LEADIN;
                            cnt_n   = '0;
                            done_n  = 1'b0;
                        end else begin
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_LEADIN: begin
                    if (cnt == 32'(LEAD_CYC - 1)) begin
                        state_n = ST_FETCH;
                        cnt_n   = '0;
                        ptr_n   = '0;
                    end else begin
                        cnt_n   = cnt + 32'd1;
                    end
                end
                ST_FETCH: begin
                    state_n   = ST_BIT_HI;
                    loading_n = 1'b1;
                end
                ST_BIT_HI: begin
                    // First BIT_HI cycle after a fetch only captures read data.
                    if (loading) begin
                        shreg_n   = make_frame(rdata);
                        bit_idx_n = '0;
                        cnt_n     = '0;
                        loading_n = 1'b0;
                    end else if (cnt == 32'(HALF_CYC - 1)) begin
                        state_n   = ST_BIT_LO;
                        cnt_n     = '0;
                    end else begin
                        cnt_n     = cnt + 32'd1;
                    end
                end
                ST_BIT_LO: begin
                    if (cnt == low_len - 32'd1) begin
                        cnt_n = '0;
                        if (bit_idx == 4'(FRAME_BITS - 1)) begin
                            if (ptr_inc < length) begin
                                ptr_n   = ptr_inc[ADDR_W-1:0];
                                state_n = ST_FETCH;
                            end else begin
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            shreg_n   = shreg >> 1;
                            bit_idx_n = bit_idx + 4'd1;
                            state_n   = ST_BIT_HI;
                        end
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign tape_out  = (state != ST_BIT_LO);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_oric_tape_player.sv
// Self-checking bench for oric_tape_player: random tape images replayed and
// measured as high/low run lengths against a frame-level reference model.
module tb_oric_tape_player;
    import oric_tape_pkg::*;

    localparam int         ADDR_W     = 6;
    localparam logic [7:0] TAPE_INDEX = 8'd1;
    localparam int         HALF       = 4;
    localparam int         LEAD       = 20;
`ifdef ORIC_TAPE_AUTOPLAY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            play, stop;
    logic            tape_out, busy, done;
    logic [ADDR_W:0] length;
    tape_state_t     state_dbg;

    oric_tape_player_if #(.ADDR_W(ADDR_W)) ioctl ();

    oric_tape_player #(
        .ADDR_W(ADDR_W), .TAPE_INDEX(TAPE_INDEX), .HALF_CYC(HALF), .LEAD_CYC(LEAD)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ioctl     (ioctl),
        .play      (play),
        .stop      (stop),
        .tape_out  (tape_out),
        .busy      (busy),
        .done      (done),
        .length    (length),
        .state_dbg (state_dbg)
    );

    always #5 clk_sys = ~clk_sys;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [7:0]  dl_data [0:63];
    logic [7:0]  img [0:63];
    int          model_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        ioctl.index    = idx;
        ioctl.download = 1'b1;
        step();
    endtask

    task automatic dl_finish(input logic [7:0] idx, input int n);
        int order[64];
        int j, tmp;
        for (int i = 0; i < n; i++) order[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
            ioctl.addr = ADDR_W'(order[i]);
            ioctl.dout = dl_data[order[i]];
            ioctl.wr   = 1'b1;
            step();
            ioctl.wr   = 1'b0;
            step();
        end
        if (idx == TAPE_INDEX) begin
            model_len = n;
            for (int i = 0; i < n; i++) img[i] = dl_data[i];
        end
        ioctl.download = 1'b0;
        step();
        check("autoplay", 32'(busy), 32'(AUTO && (idx == TAPE_INDEX) && (n > 0)));
        check("length", 32'(length), 32'(model_len));
    endtask

    task automatic download(input logic [7:0] idx, input int n);
        dl_begin(idx);
        dl_finish(idx, n);
    endtask

    task automatic start_play();
        if (!busy) begin
            play = 1'b1;
            step();
            play = 1'b0;
        end
    endtask

    task automatic wait_state(input tape_state_t st, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_sys);
            if (state_dbg == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected high/low run lengths of the whole image, derived from the frame rules.
    task automatic build_exp();
        logic [7:0] d;
        logic       bits [0:13];
        int         ones;
        exp_q.delete();
        for (int b = 0; b < model_len; b++) begin
            d = img[b];
            ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(d[k]);
            bits[0] = 1'b0;
            for (int k = 0; k < 8; k++) bits[1 + k] = d[k];
            bits[9] = ((ones % 2) == 0);
            for (int k = 10; k < 14; k++) bits[k] = 1'b1;
            for (int k = 0; k < 14; k++) begin
                if (k == 0) exp_q.push_back((b == 0) ? 32'(LEAD + 2 + HALF) : 32'(HALF + 2));
                else        exp_q.push_back(32'(HALF));
                exp_q.push_back(bits[k] ? 32'(HALF) : 32'(2 * HALF));
            end
        end
    endtask

    task automatic play_and_check(input string tag);
        bit   found, fin;
        logic cur;
        int   run;
        build_exp();
        got_q.delete();
        start_play();
        found = 1'b0;
        fin   = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk_sys);
            if (busy) found = 1'b1;
        end
        check({tag, "_busy_rise"}, 32'(found), 32'd1);
        if (found) begin
            cur = 1'b1;
            run = 1;
            for (int k = 0; k < 20000; k++) begin
                @(negedge clk_sys);
                if (!busy) begin
                    got_q.push_back(32'(run));
                    fin = 1'b1;
                    break;
                end
                if (tape_out == cur) begin
                    run++;
                end else begin
                    got_q.push_back(32'(run));
                    cur = tape_out;
                    run = 1;
                end
            end
        end
        check({tag, "_end"}, 32'(fin), 32'd1);
        check({tag, "_runs"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_run"}, got_q.pop_front(), exp_q.pop_front());
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle_line"}, 32'(tape_out), 32'd1);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   any_busy;
        int   n;
        reset          = 1'b1;
        play           = 1'b0;
        stop           = 1'b0;
        ioctl.download = 1'b0;
        ioctl.index    = 8'd0;
        ioctl.wr       = 1'b0;
        ioctl.addr     = '0;
        ioctl.dout     = 8'd0;
        repeat (3) step();
        check("rst_tape_out", 32'(tape_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_length", 32'(length), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        step();

        // Fixed image from the bring-up notes.
        dl_data[0] = 8'h16; dl_data[1] = 8'h16; dl_data[2] = 8'h24;
        download(TAPE_INDEX, 3);
        play_and_check("fixed");

        // Foreign index is ignored.
        download(8'd2, 4);

        // All-ones byte exercises parity and the short low phases.
        dl_data[0] = 8'hFF;
        download(TAPE_INDEX, 1);
        play_and_check("ff");

        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) dl_data[i] = 8'($urandom_range(0, 255));
            download(TAPE_INDEX, n);
            play_and_check("rand");
        end

        // Stop during a low phase.
        for (int i = 0; i < 2; i++) dl_data[i] = 8'($urandom_range(0, 255));
        download(TAPE_INDEX, 2);
        start_play();
        wait_state(ST_BIT_LO, 200, ok);
        check("stop_reach_lo", 32'(ok), 32'd1);
        stop = 1'b1;
        step();
        check("stop_state", 32'(state_dbg), 32'(ST_IDLE));
        check("stop_tape_out", 32'(tape_out), 32'd1);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        stop = 1'b0;
        step();

        // New tape download aborts playback.
        for (int i = 0; i < 3; i++) dl_data[i] = 8'($urandom_range(0, 255));
        download(TAPE_INDEX, 3);
        start_play();
        wait_state(ST_BIT_HI, 200, ok);
        check("abort_reach_hi", 32'(ok), 32'd1);
        dl_begin(TAPE_INDEX);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_tape_out", 32'(tape_out), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_length", 32'(length), 32'd0);
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) dl_data[i] = 8'($urandom_range(0, 255));
        dl_finish(TAPE_INDEX, n);
        play_and_check("after_abort");

        // Asynchronous reset while the line is low.
        for (int i = 0; i < 2; i++) dl_data[i] = 8'($urandom_range(0, 255));
        download(TAPE_INDEX, 2);
        start_play();
        wait_state(ST_BIT_LO, 200, ok);
        check("rst2_reach_lo", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        model_len = 0;
        check("rst2_tape_out", 32'(tape_out), 32'd1);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_done", 32'(done), 32'd0);
        check("rst2_length", 32'(length), 32'd0);
        check("rst2_state", 32'(state_dbg), 32'(ST_IDLE));
        step();
        reset = 1'b0;
        step();

        // Foreign-index download leaves the buffer empty; play just flags done.
        download(8'd2, 3);
        start_play();
        check("empty_done", 32'(done), 32'd1);
        any_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            any_busy |= busy;
            step();
        end
        check("empty_no_busy", 32'(any_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
